// File: rtl/packer_pkg.sv
// packer_pkg: shared widths and the symbol-placement helper for the
// 2-bit to 8-bit packer.
//   SYM_W         width of one input symbol
//   WORD_W        width of one packed output word
//   SYMS_PER_WORD symbols needed to complete a word
//   CNT_W         width of the per-word symbol counter
package packer_pkg;

  localparam int SYM_W         = 2;
  localparam int WORD_W        = 8;
  localparam int SYMS_PER_WORD = WORD_W / SYM_W;
  localparam int CNT_W         = $clog2(SYMS_PER_WORD);
  localparam int LO_W          = $clog2(WORD_W);

  // Returns 'word' with 'sym' written into the slot of symbol number 'idx'.
  // msb_first=1: symbol 0 occupies the top slot, later symbols move down.
  // msb_first=0: symbol 0 occupies the bottom slot, later symbols move up.
  function automatic logic [WORD_W-1:0] place_sym(
    input logic [WORD_W-1:0] word,
    input logic [SYM_W-1:0]  sym,
    input logic [CNT_W-1:0]  idx,
    input logic              msb_first
  );
    logic [WORD_W-1:0] res;
    logic [LO_W-1:0]   lo;
    lo = LO_W'(idx) * LO_W'(SYM_W);
    if (msb_first) lo = LO_W'(WORD_W - SYM_W) - lo;
    res = word;
    res[lo +: SYM_W] = sym;
    return res;
  endfunction

endpackage

// File: rtl/packer_2b_to_8b_fifo_sync.sv
// fifo_sync: single-clock FIFO with first-word fall-through read.
//   clk      rising-edge clock
//   reset_L  asynchronous active-low reset (clears pointers, count, storage)
//   push     write wdata this cycle (ignored when full)
//   pop      advance past the head entry this cycle (ignored when empty)
//   wdata    write data
//   rdata    head entry, combinational from the read pointer
//   count    entries held, 0..DEPTH
//   full     count == DEPTH
//   empty    count == 0
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr_q] <= wdata;
        wptr_q      <= wptr_q + 1'b1;   // DEPTH is a power of two: natural wrap
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/packer_2b_to_8b.sv
// packer_2b_to_8b: collects four 2-bit symbols into an 8-bit word and queues
// finished words in a FWFT FIFO for a downstream consumer.
//   clk         rising-edge clock
//   reset_L     asynchronous active-low reset
//   valid_in    data_in carries a symbol
//   data_in     2-bit symbol
//   ready_in    a symbol offered this cycle will be taken
//   flush       discard the partially assembled word
//   pop         consumer takes data_out
//   valid_out   FIFO not empty, data_out valid
//   data_out    head-of-FIFO word
//   fifo_count  words held, 0..DEPTH
//   err_drop    sticky: a symbol was offered while ready_in was low
//
// Handshakes: input side transfers on valid_in & ready_in; ready_in depends
// only on registered state. Output side transfers on pop & valid_out; pop
// while valid_out is low is ignored.
module packer_2b_to_8b
  import packer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   valid_in,
  input  logic [SYM_W-1:0]       data_in,
  output logic                   ready_in,
  input  logic                   flush,
  input  logic                   pop,
  output logic                   valid_out,
  output logic [WORD_W-1:0]      data_out,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err_drop
);

  logic [CNT_W-1:0]  sym_cnt_q;
  logic [WORD_W-1:0] shift_q;
  logic              err_q;
  logic              last_slot;
  logic              accept;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] word_next;

  assign last_slot = (sym_cnt_q == CNT_W'(SYMS_PER_WORD - 1));

  // Only the word-completing symbol is ever stalled; earlier symbols are
  // always accepted even when the FIFO is full.
  assign ready_in  = ~(last_slot & fifo_full);
  assign accept    = valid_in & ready_in;
  assign push      = accept & last_slot & ~flush;

  // Partial word with the current symbol merged in; on the last symbol this
  // is the complete word that goes straight into the FIFO.
  assign word_next = place_sym(shift_q, data_in, sym_cnt_q, MSB_FIRST);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sym_cnt_q <= '0;
      shift_q   <= '0;
    end else if (flush) begin
      sym_cnt_q <= '0;
      shift_q   <= '0;
    end else if (accept) begin
      if (last_slot) begin
        sym_cnt_q <= '0;
        shift_q   <= '0;
      end else begin
        sym_cnt_q <= sym_cnt_q + 1'b1;
        shift_q   <= word_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                  err_q <= 1'b0;
    else if (valid_in & ~ready_in) err_q <= 1'b1;
  end

  assign err_drop = err_q;

  fifo_sync #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push),
    .pop     (pop),
    .wdata   (word_next),
    .rdata   (data_out),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign valid_out = ~fifo_empty;

endmodule

// File: tb/tb_packer_2b_to_8b.sv
module tb_packer_2b_to_8b;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  // DUT A: MSB_FIRST=1
  logic       valid_in, ready_in, flush, pop, valid_out, err_drop;
  logic [1:0] data_in;
  logic [7:0] data_out;
  logic [2:0] fifo_count;

  // DUT B: MSB_FIRST=0
  logic       valid_in0, ready_in0, flush0, pop0, valid_out0, err_drop0;
  logic [1:0] data_in0;
  logic [7:0] data_out0;
  logic [2:0] fifo_count0;

  packer_2b_to_8b #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .flush(flush), .pop(pop), .valid_out(valid_out),
    .data_out(data_out), .fifo_count(fifo_count), .err_drop(err_drop)
  );

  packer_2b_to_8b #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in0), .data_in(data_in0),
    .ready_in(ready_in0), .flush(flush0), .pop(pop0), .valid_out(valid_out0),
    .data_out(data_out0), .fifo_count(fifo_count0), .err_drop(err_drop0)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] exp0_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // monitors: compare the head word whenever the consumer takes it
  always @(negedge clk) begin
    if (reset_L && pop && valid_out) begin
      if (exp_q.size() == 0) chk("mon_a_unexpected_word", {24'h0, data_out}, 32'hFFFF_FFFF);
      else                   chk("mon_a_word", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (reset_L && pop0 && valid_out0) begin
      if (exp0_q.size() == 0) chk("mon_b_unexpected_word", {24'h0, data_out0}, 32'hFFFF_FFFF);
      else                    chk("mon_b_word", {24'h0, data_out0}, {24'h0, exp0_q.pop_front()});
    end
  end

  // drivers: every task starts and ends one time unit after a rising edge
  task automatic send_sym(input logic [1:0] s);
    valid_in = 1'b1; data_in = s;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_sym0(input logic [1:0] s);
    valid_in0 = 1'b1; data_in0 = s;
    @(posedge clk); #1;
    valid_in0 = 1'b0;
  endtask

  // MSB-first symbol k of word w is w[7-2k -: 2]
  task automatic send_word(input logic [7:0] w);
    logic [7:0] t;
    t = w;
    for (int k = 0; k < 4; k++) send_sym(t[7-2*k -: 2]);
    exp_q.push_back(w);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] w5;
  logic [7:0] tbl [4];

  initial begin
    reset_L = 1'b0;
    valid_in = 0; data_in = 0; flush = 0; pop = 0;
    valid_in0 = 0; data_in0 = 0; flush0 = 0; pop0 = 0;
    tbl[0] = 8'h1B; tbl[1] = 8'hE4; tbl[2] = 8'hA5; tbl[3] = 8'h3C;
    w5 = 8'h96;

    // reset state
    #2;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_err_drop", err_drop, 0);
    @(negedge clk); reset_L = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_in", ready_in, 1);

    // MSB-first basic word 11,00,10,01 -> C9
    send_sym(2'b11); send_sym(2'b00); send_sym(2'b10); send_sym(2'b01);
    exp_q.push_back(8'hC9);
    chk("c9_valid_out", valid_out, 1);
    chk("c9_data_out", data_out, 8'hC9);
    chk("c9_fifo_count", fifo_count, 1);
    do_pop();
    chk("c9_empty_valid_out", valid_out, 0);
    chk("c9_empty_count", fifo_count, 0);
    do_pop();  // pop on empty is ignored
    chk("pop_empty_count", fifo_count, 0);

    // LSB-first instance, same symbols -> 63
    send_sym0(2'b11); send_sym0(2'b00); send_sym0(2'b10); send_sym0(2'b01);
    exp0_q.push_back(8'h63);
    chk("lsb_data_out", data_out0, 8'h63);
    chk("lsb_fifo_count", fifo_count0, 1);
    pop0 = 1'b1; @(posedge clk); #1; pop0 = 1'b0;
    chk("lsb_empty", valid_out0, 0);

    // fill FIFO, stall the word-completing symbol
    for (int i = 0; i < 4; i++) send_word(tbl[i]);
    chk("full_count", fifo_count, 4);
    chk("full_ready_cnt0", ready_in, 1);
    send_sym(w5[7:6]); send_sym(w5[5:4]);
    chk("full_ready_cnt2", ready_in, 1);
    send_sym(w5[3:2]);
    chk("full_ready_cnt3", ready_in, 0);
    chk("full_no_err_yet", err_drop, 0);
    send_sym(w5[1:0]);  // refused
    chk("drop_err", err_drop, 1);
    chk("drop_count", fifo_count, 4);
    do_pop();
    chk("after_pop_count", fifo_count, 3);
    chk("after_pop_ready", ready_in, 1);
    send_sym(w5[1:0]);
    exp_q.push_back(w5);
    chk("refill_count", fifo_count, 4);
    chk("err_sticky", err_drop, 1);
    repeat (4) do_pop();
    chk("drain_count", fifo_count, 0);

    // push and pop together with two words queued
    send_word(8'h12); send_word(8'h34);
    send_sym(2'b01); send_sym(2'b11); send_sym(2'b10);
    pop = 1'b1;
    send_sym(2'b00);
    pop = 1'b0;
    exp_q.push_back(8'h78);
    chk("pushpop_count", fifo_count, 2);
    chk("pushpop_head", data_out, 8'h34);
    repeat (2) do_pop();
    chk("pushpop_drained", fifo_count, 0);

    // flush alone, then flush together with an accept
    send_sym(2'b10); send_sym(2'b11);
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    send_sym(2'b11); send_sym(2'b10); send_sym(2'b11);
    flush = 1'b1; send_sym(2'b11); flush = 1'b0;
    chk("flush_no_push", fifo_count, 0);
    send_word(8'h55);
    chk("flush_data_out", data_out, 8'h55);
    chk("flush_count", fifo_count, 1);
    do_pop();

    // asynchronous reset mid-word and mid-drain
    send_word(8'hA1); send_word(8'hB2); send_word(8'hC3);
    send_sym(2'b01); send_sym(2'b10);
    chk("pre_rst_count", fifo_count, 3);
    #3 reset_L = 1'b0;
    #1;
    chk("async_rst_valid_out", valid_out, 0);
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_data_out", data_out, 8'h00);
    chk("async_rst_err", err_drop, 0);
    exp_q.delete();
    @(negedge clk); reset_L = 1'b1;
    @(posedge clk); #1;

    // clean word after reset: no residue from the lost partial symbols
    send_word(8'h2D);
    chk("post_rst_data_out", data_out, 8'h2D);
    do_pop();
    idle(2);

    chk("queue_a_empty", exp_q.size(), 0);
    chk("queue_b_empty", exp0_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
